// File: rtl/sdc_fifo_pkg.sv
// Shared constants and helpers for the single-clock SD FIFO controller.
package sdc_fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefAeLevel   = 2;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned af_level_default(int unsigned addr_width);
    return (1 << addr_width) - 2;
  endfunction

endpackage

// File: rtl/sdc_fifo_ptr_cnt.sv
// Read/write pointers, occupancy count and registered status flags.
module sdc_fifo_ptr_cnt
  import sdc_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned AF_LEVEL   = af_level_default(ADDR_WIDTH),
  parameter int unsigned AE_LEVEL   = DefAeLevel
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_ok,
  input  logic              rd_ok,
  output logic [ADDR_WIDTH:0] wptr,
  output logic [ADDR_WIDTH:0] rptr,
  output logic [ADDR_WIDTH:0] count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int unsigned PtrW = ptr_width(ADDR_WIDTH);
  localparam logic [PtrW-1:0] Depth = PtrW'(1 << ADDR_WIDTH);

  logic [PtrW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + PtrW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = count - PtrW'(1);
    end
  end

  // Flags are registered from the next count so they line up with count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + PtrW'(1);
      if (rd_ok) rptr <= rptr + PtrW'(1);
      count        <= count_next;
      full         <= (count_next == Depth);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= PtrW'(AF_LEVEL));
      almost_empty <= (count_next <= PtrW'(AE_LEVEL));
    end
  end

endmodule

// File: rtl/sdc_fifo_sc_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM
// (port A writes, port B registered reads).
module sdc_fifo_sc_ctrl
  import sdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned AF_LEVEL   = af_level_default(ADDR_WIDTH),
  parameter int unsigned AE_LEVEL   = DefAeLevel
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;

  // Accept decisions look only at registered flags, never at same-cycle traffic.
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  sdc_fifo_ptr_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_ptr_cnt (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .wptr         (wptr),
    .rptr         (rptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  assign ram_we_a  = wr_ok;
  assign ram_adr_a = wptr[ADDR_WIDTH-1:0];
  assign ram_d_a   = wr_data;
  assign ram_adr_b = rptr[ADDR_WIDTH-1:0];
  assign ram_we_b  = 1'b0;
  assign rd_data   = ram_q_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (flush) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en && full)  overflow  <= 1'b1;
        if (rd_en && empty) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdc_fifo_sc_ctrl.sv
// Directed self-checking bench for sdc_fifo_sc_ctrl with a behavioural RAM.
module tb_sdc_fifo_sc_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [AW-1:0] ram_adr_a;
  logic [DW-1:0] ram_d_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_adr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_q_b;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  sdc_fifo_sc_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_adr_a    (ram_adr_a),
    .ram_d_a      (ram_d_a),
    .ram_we_a     (ram_we_a),
    .ram_adr_b    (ram_adr_b),
    .ram_we_b     (ram_we_b),
    .ram_q_b      (ram_q_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) tick();
    checks += 9;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", underflow); end
    if (ram_we_b !== 1'b0) begin failures++; $display("FAIL reset_we_b got=%b exp=0", ram_we_b); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [DW-1:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = d[i];
      #1;
      checks += 2;
      if (ram_we_a !== 1'b1) begin failures++; $display("FAIL fill_we_a[%0d] got=%b exp=1", i, ram_we_a); end
      if (ram_adr_a !== 2'(i)) begin failures++; $display("FAIL fill_adr_a[%0d] got=%0d exp=%0d", i, ram_adr_a, i); end
      tick();
      checks++;
      if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    wr_en = 1'b0;
    checks += 4;
    if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_af got=%b exp=1", almost_full); end
    if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", empty); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
    #1;
    checks++;
    if (ram_we_a !== 1'b0) begin failures++; $display("FAIL ovf_we_a got=%b exp=0", ram_we_a); end
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks += 5;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (count !== 3'd3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", count); end
    if (full !== 1'b0) begin failures++; $display("FAIL ovf_full got=%b exp=0", full); end
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL ovf_rd_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 8'h11) begin failures++; $display("FAIL ovf_rd_data got=%h exp=11", rd_data); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] d [3];
    d = '{8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      checks += 2;
      if (rd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, rd_valid); end
      if (rd_data !== d[i]) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, d[i]); end
    end
    checks += 3;
    if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL drain_unf_early got=%b exp=0", underflow); end
    tick();
    rd_en = 1'b0;
    checks += 3;
    if (underflow !== 1'b1) begin failures++; $display("FAIL drain_unf got=%b exp=1", underflow); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_extra_valid got=%b exp=0", rd_valid); end
    if (count !== 3'd0) begin failures++; $display("FAIL drain_extra_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd2) begin failures++; $display("FAIL b2b_pre_count got=%0d exp=2", count); end
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hB0 + 8'(i); q.push_back(wr_data);
      #1;
      checks += 2;
      if (ram_adr_a !== 2'(2 + i)) begin failures++; $display("FAIL b2b_adr_a[%0d] got=%0d exp=%0d", i, ram_adr_a, (2 + i) % 4); end
      if (ram_adr_b !== 2'(i)) begin failures++; $display("FAIL b2b_adr_b[%0d] got=%0d exp=%0d", i, ram_adr_b, i % 4); end
      tick();
      exp_d = q.pop_front();
      checks += 3;
      if (rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, rd_valid); end
      if (rd_data !== exp_d) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, exp_d); end
      if (count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp_d;
    checks += 2;
    if (overflow !== 1'b1) begin failures++; $display("FAIL flush_ovf_sticky got=%b exp=1", overflow); end
    if (underflow !== 1'b1) begin failures++; $display("FAIL flush_unf_sticky got=%b exp=1", underflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_d = q.pop_front();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    #1;
    checks += 3;
    if (ram_we_a !== 1'b0) begin failures++; $display("FAIL flush1_we_a got=%b exp=0", ram_we_a); end
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL flush1_valid got=%b exp=1", rd_valid); end
    if (rd_data !== exp_d) begin failures++; $display("FAIL flush1_data got=%h exp=%h", rd_data, exp_d); end
    tick();
    flush = 1'b0; wr_en = 1'b0;
    q.delete();
    checks += 5;
    if (count !== 3'd0) begin failures++; $display("FAIL flush1_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL flush1_empty got=%b exp=1", empty); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL flush1_ovf got=%b exp=0", overflow); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL flush1_unf got=%b exp=0", underflow); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL flush1_valid_after got=%b exp=0", rd_valid); end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hC1 + 8'(i);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin failures++; $display("FAIL flush2_pre_count got=%0d exp=3", count); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hC4;
    #1;
    checks++;
    if (ram_we_a !== 1'b0) begin failures++; $display("FAIL flush2_we_a got=%b exp=0", ram_we_a); end
    tick();
    flush = 1'b0; wr_en = 1'b0;
    checks += 5;
    if (count !== 3'd0) begin failures++; $display("FAIL flush2_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL flush2_empty got=%b exp=1", empty); end
    if (almost_full !== 1'b0) begin failures++; $display("FAIL flush2_af got=%b exp=0", almost_full); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL flush2_ovf got=%b exp=0", overflow); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL flush2_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_data = 8'hD1;
    tick();
    wr_data = 8'hD2; rd_en = 1'b1;
    tick();
    checks += 2;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", rd_valid); end
    if (count !== 3'd1) begin failures++; $display("FAIL arst_pre_count got=%0d exp=1", count); end
    rd_en = 1'b0; wr_data = 8'hD3;
    #3;
    rst = 1'b1;
    #1;
    checks += 5;
    if (count !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", empty); end
    if (almost_empty !== 1'b1) begin failures++; $display("FAIL arst_ae got=%b exp=1", almost_empty); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", rd_valid); end
    if (ram_adr_a !== 2'd0) begin failures++; $display("FAIL arst_adr_a got=%0d exp=0", ram_adr_a); end
    wr_en = 1'b0;
    tick();
    #4;
    rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'hE1;
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd1) begin failures++; $display("FAIL resume_count got=%0d exp=1", count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks += 3;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL resume_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 8'hE1) begin failures++; $display("FAIL resume_data got=%h exp=e1", rd_data); end
    if (empty !== 1'b1) begin failures++; $display("FAIL resume_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
